// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared register, operand-select and FSM codes for the decode/execute hazard controller.
// Pure definitions: no logic, no latency, no flow control.
package pipe_hazard_ctrl_pkg;

  localparam int REG_ADDR_BUS = 5;
  localparam logic [REG_ADDR_BUS-1:0] REG_ZERO = '0;

  localparam logic [2:0] LSEL_REG = 3'd0;
  localparam logic [2:0] LSEL_EX  = 3'd1;
  localparam logic [2:0] LSEL_MEM = 3'd2;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_LU_STALL = 2'd1,
    HZ_EX_WAIT  = 2'd2
  } hz_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Per-operand forwarding select and load-use match against the EX/MEM trackers.
// Combinational, 0 cycles; no backpressure of its own.
module hazard_fwd_sel
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_ADDR_BUS
) (
  input  logic              rd_en,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              ex_vld,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_load,
  input  logic              mem_vld,
  input  logic [REG_AW-1:0] mem_dest,
  output logic [2:0]        sel,
  output logic              lu_match
);

  logic live, ex_hit, mem_hit;

  // r0 is hardwired, so a read of it never matches any producer
  assign live    = rd_en && (rd_addr != REG_AW'(REG_ZERO));
  assign ex_hit  = live && ex_vld  && (rd_addr == ex_dest);
  assign mem_hit = live && mem_vld && (rd_addr == mem_dest);

  always_comb begin
    sel = LSEL_REG;
    if (ex_hit && !ex_load) sel = LSEL_EX;
    else if (mem_hit)       sel = LSEL_MEM;
  end

  assign lu_match = ex_hit && ex_load;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decode/execute hazard controller: 0-cycle Mealy stall/bubble/forward selects; IF/ID held on load-use and busy EX.
// Optional saturating stall counters exist only when HAZARD_STALL_CNT_EN is defined.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_ADDR_BUS
`ifdef HAZARD_STALL_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_idValid,
  input  logic              i_readEnableLeft,
  input  logic [REG_AW-1:0] i_readAddrLeft,
  input  logic              i_readEnableRight,
  input  logic [REG_AW-1:0] i_readAddrRight,
  input  logic [REG_AW-1:0] i_dest,
  input  logic              i_isLoad,
  input  logic              i_exBusy,
  input  logic              i_flush,
  output logic              o_stallIF,
  output logic              o_stallID,
  output logic              o_bubbleEX,
  output logic [2:0]        o_selLeft,
  output logic [2:0]        o_selRight
`ifdef HAZARD_STALL_CNT_EN
  , output logic [CNT_W-1:0] o_luStallCnt,
  output logic [CNT_W-1:0]   o_busyStallCnt
`endif
);

  hz_state_t         state, cur;
  logic              ex_vld, ex_load, mem_vld;
  logic [REG_AW-1:0] ex_dest, mem_dest;
  logic              flush_held, flush_eff;
  logic              lu_left, lu_right, load_use;

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_sel_left (
    .rd_en(i_readEnableLeft), .rd_addr(i_readAddrLeft),
    .ex_vld(ex_vld), .ex_dest(ex_dest), .ex_load(ex_load),
    .mem_vld(mem_vld), .mem_dest(mem_dest),
    .sel(o_selLeft), .lu_match(lu_left)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_sel_right (
    .rd_en(i_readEnableRight), .rd_addr(i_readAddrRight),
    .ex_vld(ex_vld), .ex_dest(ex_dest), .ex_load(ex_load),
    .mem_vld(mem_vld), .mem_dest(mem_dest),
    .sel(o_selRight), .lu_match(lu_right)
  );

  // A flush seen while ID is held is remembered and applied when ID finally advances
  assign flush_eff = i_flush || flush_held;
  assign load_use  = i_idValid && (lu_left || lu_right);

  // cur is the state this cycle actually behaves as; a busy EX outranks load-use, a flush cancels it
  always_comb begin
    cur = HZ_RUN;
    if (i_exBusy)
      cur = HZ_EX_WAIT;
    else if (load_use && !flush_eff && state != HZ_LU_STALL)
      cur = HZ_LU_STALL;
  end

  assign o_stallIF  = (cur != HZ_RUN);
  assign o_stallID  = (cur != HZ_RUN);
  assign o_bubbleEX = (cur == HZ_LU_STALL) || (cur == HZ_RUN && flush_eff && i_idValid);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= HZ_RUN;
      ex_vld     <= 1'b0;
      ex_dest    <= '0;
      ex_load    <= 1'b0;
      mem_vld    <= 1'b0;
      mem_dest   <= '0;
      flush_held <= 1'b0;
    end else begin
      state <= cur;
      case (cur)
        HZ_EX_WAIT: begin
          mem_vld    <= 1'b0;
          flush_held <= flush_eff;
        end
        HZ_LU_STALL: begin
          ex_vld   <= 1'b0;
          mem_vld  <= ex_vld;
          mem_dest <= ex_dest;
        end
        default: begin
          ex_vld     <= i_idValid && !flush_eff;
          ex_dest    <= i_dest;
          ex_load    <= i_isLoad;
          mem_vld    <= ex_vld;
          mem_dest   <= ex_dest;
          flush_held <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_luStallCnt   <= '0;
      o_busyStallCnt <= '0;
    end else begin
      if (cur == HZ_LU_STALL && o_luStallCnt != '1)
        o_luStallCnt <= o_luStallCnt + CNT_W'(1);
      if (cur == HZ_EX_WAIT && o_busyStallCnt != '1)
        o_busyStallCnt <= o_busyStallCnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, load-use, r0, busy EX, flush and reset scenarios.
module tb_pipe_hazard_ctrl;

  localparam logic [2:0] SEL_REG = 3'd0;
  localparam logic [2:0] SEL_EX  = 3'd1;
  localparam logic [2:0] SEL_MEM = 3'd2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0, re_l = 1'b0, re_r = 1'b0, is_load = 1'b0, ex_busy = 1'b0, flush = 1'b0;
  logic [4:0] ra_l = '0, ra_r = '0, dest = '0;
  logic       stall_if, stall_id, bubble_ex;
  logic [2:0] sel_l, sel_r;
  logic [2:0] flags;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] lu_cnt, busy_cnt;
`endif

  int checks = 0;
  int failures = 0;

  assign flags = {stall_if, stall_id, bubble_ex};

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_idValid(id_valid),
    .i_readEnableLeft(re_l), .i_readAddrLeft(ra_l),
    .i_readEnableRight(re_r), .i_readAddrRight(ra_r),
    .i_dest(dest), .i_isLoad(is_load), .i_exBusy(ex_busy), .i_flush(flush),
    .o_stallIF(stall_if), .o_stallID(stall_id), .o_bubbleEX(bubble_ex),
    .o_selLeft(sel_l), .o_selRight(sel_r)
`ifdef HAZARD_STALL_CNT_EN
    , .o_luStallCnt(lu_cnt), .o_busyStallCnt(busy_cnt)
`endif
  );

  task automatic drive(input logic v, input logic el, input logic [4:0] al,
                       input logic er, input logic [4:0] ar, input logic [4:0] d, input logic ld);
    id_valid = v; re_l = el; ra_l = al; re_r = er; ra_r = ar; dest = d; is_load = ld;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    ex_busy = 1'b0; flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick; tick;
  endtask

  task automatic test_reset;
    drive(0, 1, 5, 1, 6, 7, 1);
    #2;
    checks++; if (flags !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", flags); end
    checks++; if (sel_l !== SEL_REG) begin failures++; $display("FAIL reset_sel_l got=%0d exp=%0d", sel_l, SEL_REG); end
    checks++; if (sel_r !== SEL_REG) begin failures++; $display("FAIL reset_sel_r got=%0d exp=%0d", sel_r, SEL_REG); end
`ifdef HAZARD_STALL_CNT_EN
    checks++; if (lu_cnt !== 32'd0 || busy_cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", lu_cnt, busy_cnt); end
`endif
    @(negedge clk); rst_n = 1'b1;
    drain;
  endtask

  task automatic test_forward;
    drive(1, 1, 0, 0, 0, 1, 0);                       // ORI r1
    checks++; if (flags !== 3'b000 || sel_l !== SEL_REG) begin failures++; $display("FAIL ori flags=%b sel_l=%0d exp=000/%0d", flags, sel_l, SEL_REG); end
    tick; drive(1, 1, 1, 0, 1, 2, 0);                 // ANDI r2<-r1, right port disabled
    checks++; if (flags !== 3'b000 || sel_l !== SEL_EX) begin failures++; $display("FAIL fwd_ex flags=%b sel_l=%0d exp=000/%0d", flags, sel_l, SEL_EX); end
    checks++; if (sel_r !== SEL_REG) begin failures++; $display("FAIL fwd_re_off sel_r=%0d exp=%0d", sel_r, SEL_REG); end
    tick; drive(1, 1, 1, 1, 2, 1, 0);
    checks++; if (sel_l !== SEL_MEM || sel_r !== SEL_EX) begin failures++; $display("FAIL fwd_mem sel=%0d/%0d exp=%0d/%0d", sel_l, sel_r, SEL_MEM, SEL_EX); end
    tick; drive(1, 1, 1, 1, 2, 1, 0);
    checks++; if (sel_l !== SEL_EX || sel_r !== SEL_MEM) begin failures++; $display("FAIL fwd_swap sel=%0d/%0d exp=%0d/%0d", sel_l, sel_r, SEL_EX, SEL_MEM); end
    tick; drive(1, 1, 1, 1, 3, 0, 0);
    checks++; if (sel_l !== SEL_EX || sel_r !== SEL_REG) begin failures++; $display("FAIL fwd_double sel=%0d/%0d exp=%0d/%0d", sel_l, sel_r, SEL_EX, SEL_REG); end
    tick; drive(0, 1, 1, 0, 0, 7, 1);                 // invalid load to r7 must be ignored
    checks++; if (flags !== 3'b000 || sel_l !== SEL_MEM) begin failures++; $display("FAIL invalid_id flags=%b sel_l=%0d exp=000/%0d", flags, sel_l, SEL_MEM); end
    tick; drive(1, 1, 7, 1, 7, 5, 0);
    checks++; if (flags !== 3'b000 || sel_l !== SEL_REG || sel_r !== SEL_REG) begin failures++; $display("FAIL invalid_track flags=%b sel=%0d/%0d exp=000/0/0", flags, sel_l, sel_r); end
    drain;
  endtask

  task automatic test_load_use;
    drive(1, 1, 1, 0, 0, 3, 1);                       // LW r3
    checks++; if (flags !== 3'b000) begin failures++; $display("FAIL lw flags=%b exp=000", flags); end
    tick; drive(1, 1, 3, 1, 5, 4, 0);                 // OR r4,r3,r5
    checks++; if (flags !== 3'b111) begin failures++; $display("FAIL lu_stall flags=%b exp=111", flags); end
    tick; drive(1, 1, 3, 1, 5, 4, 0);
    checks++; if (flags !== 3'b000) begin failures++; $display("FAIL lu_once flags=%b exp=000", flags); end
    checks++; if (sel_l !== SEL_MEM || sel_r !== SEL_REG) begin failures++; $display("FAIL lu_mem sel=%0d/%0d exp=%0d/%0d", sel_l, sel_r, SEL_MEM, SEL_REG); end
    tick; drive(1, 1, 4, 1, 3, 0, 0);
    checks++; if (sel_l !== SEL_EX || sel_r !== SEL_REG || flags !== 3'b000) begin failures++; $display("FAIL lu_after sel=%0d/%0d flags=%b exp=%0d/%0d/000", sel_l, sel_r, flags, SEL_EX, SEL_REG); end
    tick; drive(1, 0, 0, 0, 0, 6, 1);                 // LW r6, used on the right
    tick; drive(1, 1, 2, 1, 6, 8, 0);
    checks++; if (flags !== 3'b111) begin failures++; $display("FAIL lu_right flags=%b exp=111", flags); end
    tick; drive(1, 1, 2, 1, 6, 8, 0);
    checks++; if (flags !== 3'b000 || sel_r !== SEL_MEM) begin failures++; $display("FAIL lu_right_mem flags=%b sel_r=%0d exp=000/%0d", flags, sel_r, SEL_MEM); end
`ifdef HAZARD_STALL_CNT_EN
    checks++; if (lu_cnt !== 32'd2) begin failures++; $display("FAIL lu_cnt got=%0d exp=2", lu_cnt); end
`endif
    drain;
  endtask

  task automatic test_r0;
    drive(1, 0, 0, 0, 0, 0, 1);                       // load into r0
    tick; drive(1, 1, 0, 1, 0, 0, 0);
    checks++; if (flags !== 3'b000 || sel_l !== SEL_REG || sel_r !== SEL_REG) begin failures++; $display("FAIL r0_ex flags=%b sel=%0d/%0d exp=000/0/0", flags, sel_l, sel_r); end
    tick; drive(1, 1, 0, 1, 0, 9, 0);
    checks++; if (flags !== 3'b000 || sel_l !== SEL_REG || sel_r !== SEL_REG) begin failures++; $display("FAIL r0_mem flags=%b sel=%0d/%0d exp=000/0/0", flags, sel_l, sel_r); end
    drain;
  endtask

  task automatic test_ex_busy;
    drive(1, 0, 0, 0, 0, 9, 0);
    tick; drive(1, 0, 0, 0, 0, 5, 0);
    tick; ex_busy = 1'b1; drive(1, 1, 5, 1, 9, 6, 0);
    checks++; if (flags !== 3'b110 || sel_l !== SEL_EX || sel_r !== SEL_MEM) begin failures++; $display("FAIL busy_first flags=%b sel=%0d/%0d exp=110/%0d/%0d", flags, sel_l, sel_r, SEL_EX, SEL_MEM); end
    for (int i = 1; i < 4; i++) begin
      tick; drive(1, 1, 5, 1, 9, 6, 0);
      checks++; if (flags !== 3'b110 || sel_l !== SEL_EX || sel_r !== SEL_REG) begin failures++; $display("FAIL busy_wait%0d flags=%b sel=%0d/%0d exp=110/%0d/%0d", i, flags, sel_l, sel_r, SEL_EX, SEL_REG); end
    end
    tick; ex_busy = 1'b0; drive(1, 1, 5, 1, 9, 6, 0);
    checks++; if (flags !== 3'b000 || sel_l !== SEL_EX) begin failures++; $display("FAIL busy_exit flags=%b sel_l=%0d exp=000/%0d", flags, sel_l, SEL_EX); end
    tick; drive(1, 1, 5, 1, 6, 0, 0);
    checks++; if (sel_l !== SEL_MEM || sel_r !== SEL_EX) begin failures++; $display("FAIL busy_adv sel=%0d/%0d exp=%0d/%0d", sel_l, sel_r, SEL_MEM, SEL_EX); end
`ifdef HAZARD_STALL_CNT_EN
    checks++; if (busy_cnt !== 32'd4) begin failures++; $display("FAIL busy_cnt got=%0d exp=4", busy_cnt); end
`endif
    drain;
  endtask

  task automatic test_flush_lu;
    drive(1, 0, 0, 0, 0, 7, 1);                       // LW r7
    tick; flush = 1'b1; drive(1, 1, 7, 0, 0, 4, 0);
    checks++; if (flags !== 3'b001) begin failures++; $display("FAIL flush_lu flags=%b exp=001", flags); end
    tick; flush = 1'b0; drive(0, 1, 4, 1, 7, 0, 0);
    checks++; if (sel_l !== SEL_REG || sel_r !== SEL_MEM) begin failures++; $display("FAIL flush_squash sel=%0d/%0d exp=%0d/%0d", sel_l, sel_r, SEL_REG, SEL_MEM); end
    drain;
  endtask

  task automatic test_flush_in_wait;
    drive(1, 0, 0, 0, 0, 2, 0);
    tick; ex_busy = 1'b1; flush = 1'b1; drive(1, 1, 2, 0, 0, 10, 0);
    checks++; if (flags !== 3'b110) begin failures++; $display("FAIL wflush_a flags=%b exp=110", flags); end
    tick; flush = 1'b0; drive(1, 1, 2, 0, 0, 10, 0);
    checks++; if (flags !== 3'b110) begin failures++; $display("FAIL wflush_b flags=%b exp=110", flags); end
    tick; ex_busy = 1'b0; drive(1, 1, 2, 0, 0, 10, 0);
    checks++; if (flags !== 3'b001) begin failures++; $display("FAIL wflush_exit flags=%b exp=001", flags); end
    tick; drive(0, 1, 10, 1, 2, 0, 0);
    checks++; if (sel_l !== SEL_REG || sel_r !== SEL_MEM) begin failures++; $display("FAIL wflush_squash sel=%0d/%0d exp=%0d/%0d", sel_l, sel_r, SEL_REG, SEL_MEM); end
`ifdef HAZARD_STALL_CNT_EN
    checks++; if (busy_cnt !== 32'd6) begin failures++; $display("FAIL wflush_cnt got=%0d exp=6", busy_cnt); end
`endif
    drain;
  endtask

  task automatic test_reset_mid;
    drive(1, 0, 0, 0, 0, 3, 1);                       // LW r3
    tick; drive(1, 1, 3, 0, 0, 4, 0);
    checks++; if (flags !== 3'b111) begin failures++; $display("FAIL rmid_stall flags=%b exp=111", flags); end
    #1; rst_n = 1'b0; #1;
    checks++; if (flags !== 3'b000 || sel_l !== SEL_REG) begin failures++; $display("FAIL rmid_async flags=%b sel_l=%0d exp=000/%0d", flags, sel_l, SEL_REG); end
`ifdef HAZARD_STALL_CNT_EN
    checks++; if (lu_cnt !== 32'd0 || busy_cnt !== 32'd0) begin failures++; $display("FAIL rmid_cnt got=%0d/%0d exp=0/0", lu_cnt, busy_cnt); end
`endif
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (flags !== 3'b000 || sel_l !== SEL_REG) begin failures++; $display("FAIL rmid_release flags=%b sel_l=%0d exp=000/%0d", flags, sel_l, SEL_REG); end
    tick; drive(1, 1, 3, 1, 4, 0, 0);
    checks++; if (sel_l !== SEL_REG || sel_r !== SEL_EX) begin failures++; $display("FAIL rmid_first sel=%0d/%0d exp=%0d/%0d", sel_l, sel_r, SEL_REG, SEL_EX); end
    drain;
  endtask

  initial begin
    test_reset;
    test_forward;
    test_load_use;
    test_r0;
    test_ex_busy;
    test_flush_lu;
    test_flush_in_wait;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
